// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: primary opcodes, ALU operation classes
// and the ID/EX control bundle.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_IMM   = 2'b11
   } aluop_t;

   // All-zero value of this struct is the NOP bubble.
   typedef struct packed {
      logic   regDst;
      logic   aluSrc;
      logic   memtoReg;
      logic   regWrite;
      logic   memRead;
      logic   memWrite;
      logic   branch;
      logic   jump;
      logic   signZero;
      aluop_t aluOp;
   } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational primary-opcode decoder; unlisted opcodes yield the NOP bundle.
module control_decode
   import mips_pkg::*;
(
   input  logic [5:0] Opcode,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (Opcode)
         OP_RTYPE: begin
            ctrl.regDst   = 1'b1;
            ctrl.regWrite = 1'b1;
            ctrl.aluOp    = ALUOP_FUNCT;
         end
         OP_ADDI: begin
            ctrl.aluSrc   = 1'b1;
            ctrl.regWrite = 1'b1;
            ctrl.aluOp    = ALUOP_ADD;
         end
         OP_SLTI: begin
            ctrl.aluSrc   = 1'b1;
            ctrl.regWrite = 1'b1;
            ctrl.aluOp    = ALUOP_IMM;
         end
         OP_ANDI, OP_ORI: begin
            ctrl.aluSrc   = 1'b1;
            ctrl.regWrite = 1'b1;
            ctrl.signZero = 1'b1;
            ctrl.aluOp    = ALUOP_IMM;
         end
         // beq/bne share one bundle; EX/MEM picks the condition from opcode[0].
         OP_BEQ, OP_BNE: begin
            ctrl.branch = 1'b1;
            ctrl.aluOp  = ALUOP_SUB;
         end
         OP_J: begin
            ctrl.jump = 1'b1;
         end
         OP_LW: begin
            ctrl.aluSrc   = 1'b1;
            ctrl.memtoReg = 1'b1;
            ctrl.regWrite = 1'b1;
            ctrl.memRead  = 1'b1;
            ctrl.aluOp    = ALUOP_ADD;
         end
         OP_SW: begin
            ctrl.aluSrc   = 1'b1;
            ctrl.memWrite = 1'b1;
            ctrl.aluOp    = ALUOP_ADD;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// ID-stage main decoder: opcode decode registered into the ID/EX control bundle.
module control_unit
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Opcode,
   output logic       RegDst,
   output logic       ALUSrc,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       Branch,
   output logic       Jump,
   output logic       SignZero,
   output logic [1:0] ALUOp
);

   ctrl_t ctrlD;
   ctrl_t ctrlQ;

   control_decode uDecode (
      .Opcode (Opcode),
      .ctrl   (ctrlD)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ctrlQ <= '0;
      else        ctrlQ <= ctrlD;
   end

   assign RegDst   = ctrlQ.regDst;
   assign ALUSrc   = ctrlQ.aluSrc;
   assign MemtoReg = ctrlQ.memtoReg;
   assign RegWrite = ctrlQ.regWrite;
   assign MemRead  = ctrlQ.memRead;
   assign MemWrite = ctrlQ.memWrite;
   assign Branch   = ctrlQ.branch;
   assign Jump     = ctrlQ.jump;
   assign SignZero = ctrlQ.signZero;
   assign ALUOp    = ctrlQ.aluOp;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues expected bundles,
// a monitor compares one edge later; async reset is checked directly.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [5:0] Opcode = 6'd35;
   logic       RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
   logic       Branch, Jump, SignZero;
   logic [1:0] ALUOp;

   control_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .Opcode   (Opcode),
      .RegDst   (RegDst),
      .ALUSrc   (ALUSrc),
      .MemtoReg (MemtoReg),
      .RegWrite (RegWrite),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .Branch   (Branch),
      .Jump     (Jump),
      .SignZero (SignZero),
      .ALUOp    (ALUOp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic [10:0] exp;
   } item_t;

   item_t sbQ[$];
   int    nChecks = 0;
   int    nFail   = 0;

   // {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,SignZero,ALUOp}
   localparam logic [10:0] E_RTYPE = 11'b100100000_10;
   localparam logic [10:0] E_ADDI  = 11'b010100000_00;
   localparam logic [10:0] E_SLTI  = 11'b010100000_11;
   localparam logic [10:0] E_ANDI  = 11'b010100001_11;
   localparam logic [10:0] E_ORI   = 11'b010100001_11;
   localparam logic [10:0] E_BEQ   = 11'b000000100_01;
   localparam logic [10:0] E_BNE   = 11'b000000100_01;
   localparam logic [10:0] E_J     = 11'b000000010_00;
   localparam logic [10:0] E_LW    = 11'b011110000_00;
   localparam logic [10:0] E_SW    = 11'b010001000_00;
   localparam logic [10:0] E_NOP   = 11'b000000000_00;

   function automatic logic [10:0] outs();
      return {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
              Branch, Jump, SignZero, ALUOp};
   endfunction

   task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: bundle is presented after every rising edge.
   initial begin
      item_t it;
      logic [10:0] o;
      forever begin
         @(posedge clk);
         #2;
         if (sbQ.size() > 0) begin
            it = sbQ.pop_front();
            o = outs();
            check($sformatf("decode op=%0d", it.op), o, it.exp);
            nChecks++;
            if ((MemRead && MemWrite) || (Branch && Jump) ||
                (RegWrite && (MemWrite || Branch || Jump))) begin
               nFail++;
               $display("FAIL invariant op=%0d: got %b", it.op, o);
            end
         end
      end
   end

   task automatic issue(input logic [5:0] op, input logic [10:0] exp);
      item_t it;
      @(negedge clk);
      Opcode = op;
      it.op = op;
      it.exp = exp;
      sbQ.push_back(it);
   endtask

   task automatic drain();
      int n = 0;
      while (sbQ.size() > 0 && n < 20) begin
         @(posedge clk);
         #3;
         n++;
      end
      nChecks++;
      if (sbQ.size() > 0) begin
         nFail++;
         $display("FAIL drain timeout: %0d entries left, required 0", sbQ.size());
         sbQ.delete();
      end
   endtask

   initial begin
      item_t it;
      // Reset asserted with no clock edge in between.
      #1 rst_n = 1'b0;
      #1 check("async reset clear", outs(), E_NOP);
      @(posedge clk); #2 check("held in reset", outs(), E_NOP);
      @(negedge clk);
      rst_n = 1'b1;
      it.op = 6'd35; it.exp = E_LW;
      sbQ.push_back(it);
      drain();

      // Full sweep, one opcode per cycle.
      issue(6'd0,  E_RTYPE);
      issue(6'd8,  E_ADDI);
      issue(6'd12, E_ANDI);
      issue(6'd4,  E_BEQ);
      issue(6'd5,  E_BNE);
      issue(6'd2,  E_J);
      issue(6'd35, E_LW);
      issue(6'd13, E_ORI);
      issue(6'd10, E_SLTI);
      issue(6'd43, E_SW);
      // Illegal opcodes give the NOP bundle.
      issue(6'd63, E_NOP);
      issue(6'd1,  E_NOP);
      issue(6'd15, E_NOP);
      issue(6'd43, E_SW);
      drain();

      // Opcode toggles between edges must not reach the outputs.
      issue(6'd13, E_ORI);
      #1 Opcode = 6'd0;
      #1 check("no change between edges a", outs(), E_SW);
      Opcode = 6'd35;
      #1 check("no change between edges b", outs(), E_SW);
      Opcode = 6'd13;
      drain();

      // Mid-stream reset during an lw sequence.
      issue(6'd35, E_LW);
      issue(6'd35, E_LW);
      @(posedge clk);
      #3;
      sbQ.delete();
      rst_n = 1'b0;
      #1 check("mid-stream async clear", outs(), E_NOP);
      @(posedge clk); #2 check("mid-stream held in reset", outs(), E_NOP);
      @(negedge clk);
      rst_n = 1'b1;
      it.op = 6'd35; it.exp = E_LW;
      sbQ.push_back(it);
      issue(6'd0, E_RTYPE);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
